// File: rtl/controle_giro_servo.sv
// Rotation sequencer for a continuous-rotation servo: turns a quarter-turn count into a timed
// rotate level, then waits a settle interval before pulsing completion.
module controle_giro_servo #(
  parameter int unsigned CICLOS_QUARTO       = 12500000,
  parameter int unsigned CICLOS_ASSENTAMENTO = 5000000,
  parameter int unsigned LARGURA_CONT        = 32
) (
  input  logic       clock_i,
  input  logic       reset_ni,
  input  logic       iniciar_i,
  input  logic [1:0] quartos_i,
  input  logic       abortar_i,
  output logic       posicao_o,
  output logic       ocupado_o,
  output logic       pronto_o,
  output logic       abortado_o,
  output logic [2:0] db_estado_o,
  output logic [1:0] db_quartos_rest_o
);

  typedef enum logic [2:0] {
    StOcioso     = 3'd0,
    StGirando    = 3'd1,
    StAssentando = 3'd2,
    StFim        = 3'd3
  } estado_e;

  localparam logic [LARGURA_CONT-1:0] FimQuarto   = LARGURA_CONT'(CICLOS_QUARTO - 1);
  localparam logic [LARGURA_CONT-1:0] FimAssentam = LARGURA_CONT'(CICLOS_ASSENTAMENTO - 1);
  localparam logic [LARGURA_CONT-1:0] Um          = LARGURA_CONT'(1);

  estado_e                 estado_q, estado_d;
  logic [LARGURA_CONT-1:0] cont_q, cont_d;
  logic [1:0]              rest_q, rest_d;
  logic                    abortado_q, abortado_d;

  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      estado_q   <= StOcioso;
      cont_q     <= '0;
      rest_q     <= '0;
      abortado_q <= 1'b0;
    end else begin
      estado_q   <= estado_d;
      cont_q     <= cont_d;
      rest_q     <= rest_d;
      abortado_q <= abortado_d;
    end
  end

  always_comb begin
    estado_d   = estado_q;
    cont_d     = cont_q;
    rest_d     = rest_q;
    abortado_d = abortado_q;
    unique case (estado_q)
      StOcioso: begin
        if (iniciar_i) begin
          rest_d     = quartos_i;
          cont_d     = '0;
          abortado_d = 1'b0;
          estado_d   = (quartos_i != 2'd0) ? StGirando : StFim;
        end
      end
      StGirando: begin
        // Abort takes priority over a quarter-turn boundary on the same cycle.
        if (abortar_i) begin
          estado_d   = StAssentando;
          cont_d     = '0;
          rest_d     = '0;
          abortado_d = 1'b1;
        end else if (cont_q == FimQuarto) begin
          cont_d = '0;
          rest_d = rest_q - 2'd1;
          if (rest_q <= 2'd1) begin
            estado_d = StAssentando;
          end
        end else begin
          cont_d = cont_q + Um;
        end
      end
      StAssentando: begin
        if (cont_q == FimAssentam) begin
          cont_d   = '0;
          estado_d = StFim;
        end else begin
          cont_d = cont_q + Um;
        end
      end
      StFim: begin
        estado_d = StOcioso;
      end
      default: begin
        estado_d = StOcioso;
        cont_d   = '0;
        rest_d   = '0;
      end
    endcase
  end

  always_comb begin
    posicao_o = 1'b0;
    ocupado_o = 1'b0;
    pronto_o  = 1'b0;
    case (estado_q)
      StGirando: begin
        posicao_o = 1'b1;
        ocupado_o = 1'b1;
      end
      StAssentando: ocupado_o = 1'b1;
      StFim: begin
        ocupado_o = 1'b1;
        pronto_o  = 1'b1;
      end
      default: ;
    endcase
  end

  assign abortado_o        = abortado_q;
  assign db_estado_o       = estado_q;
  assign db_quartos_rest_o = rest_q;

endmodule

// File: tb/tb_controle_giro_servo.sv
// Bench for controle_giro_servo: directed commands push expected profiles into a queue; a
// monitor measures each completed command at its pronto pulse and compares.
module tb_controle_giro_servo;

  localparam int unsigned CQ = 10;
  localparam int unsigned CA = 4;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       iniciar = 1'b0;
  logic [1:0] quartos = 2'd0;
  logic       abortar = 1'b0;
  logic       posicao, ocupado, pronto, abortado;
  logic [2:0] db_estado;
  logic [1:0] db_rest;

  controle_giro_servo #(
    .CICLOS_QUARTO      (CQ),
    .CICLOS_ASSENTAMENTO(CA),
    .LARGURA_CONT       (32)
  ) dut (
    .clock_i          (clock),
    .reset_ni         (reset_n),
    .iniciar_i        (iniciar),
    .quartos_i        (quartos),
    .abortar_i        (abortar),
    .posicao_o        (posicao),
    .ocupado_o        (ocupado),
    .pronto_o         (pronto),
    .abortado_o       (abortado),
    .db_estado_o      (db_estado),
    .db_quartos_rest_o(db_rest)
  );

  always #5 clock = ~clock;

  typedef struct {
    int   pos;
    int   ocu;
    int   rises;
    logic abt;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  function automatic void expect_cmd(input int pos, input int ocu, input int rises,
                                     input logic abt);
    exp_t e;
    e.pos   = pos;
    e.ocu   = ocu;
    e.rises = rises;
    e.abt   = abt;
    exp_q.push_back(e);
  endfunction

  // Called at a negedge; returns at the negedge of the first cycle after acceptance.
  task automatic issue(input logic [1:0] q);
    iniciar = 1'b1;
    quartos = q;
    @(negedge clock);
    iniciar = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (ocupado && n < 200) begin
      @(negedge clock);
      n++;
    end
    check("idle_timeout", {31'd0, ocupado}, 32'd0);
    @(negedge clock);
  endtask

  // Monitor: accumulates the profile of the running command, compares on pronto.
  int   m_pos = 0, m_ocu = 0, m_rises = 0;
  logic m_prev = 1'b0;

  always @(negedge clock) begin
    if (!reset_n) begin
      m_pos = 0; m_ocu = 0; m_rises = 0; m_prev = 1'b0;
    end else begin
      if (ocupado) m_ocu++;
      if (posicao) m_pos++;
      if (posicao && !m_prev) m_rises++;
      m_prev = posicao;
      if (pronto) begin
        if (exp_q.size() == 0) begin
          check("unexpected_pronto", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("posicao_cycles", m_pos, e.pos);
          check("ocupado_cycles", m_ocu, e.ocu);
          check("posicao_rises", m_rises, e.rises);
          check("abortado_at_pronto", {31'd0, abortado}, {31'd0, e.abt});
        end
        m_pos = 0; m_ocu = 0; m_rises = 0;
      end
    end
  end

  initial begin
    int n;
    #1;
    check("rst_posicao", {31'd0, posicao}, 32'd0);
    check("rst_ocupado", {31'd0, ocupado}, 32'd0);
    check("rst_pronto", {31'd0, pronto}, 32'd0);
    check("rst_abortado", {31'd0, abortado}, 32'd0);
    check("rst_estado", {29'd0, db_estado}, 32'd0);
    check("rst_rest", {30'd0, db_rest}, 32'd0);
    repeat (2) @(negedge clock);
    #2 reset_n = 1'b1;
    @(negedge clock);

    // 1: single quarter turn
    expect_cmd(CQ, CQ + CA + 1, 1, 1'b0);
    issue(2'd1);
    check("t1_posicao_rise", {31'd0, posicao}, 32'd1);
    wait_idle();

    // 2: three quarter turns, remaining count steps at each boundary
    expect_cmd(3 * CQ, 3 * CQ + CA + 1, 1, 1'b0);
    issue(2'd3);
    check("t2_rest_c1", {30'd0, db_rest}, 32'd3);
    repeat (9) @(negedge clock);
    check("t2_rest_c10", {30'd0, db_rest}, 32'd3);
    @(negedge clock);
    check("t2_rest_c11", {30'd0, db_rest}, 32'd2);
    repeat (10) @(negedge clock);
    check("t2_rest_c21", {30'd0, db_rest}, 32'd1);
    wait_idle();

    // 3: zero quarter turns goes straight to the pronto pulse
    expect_cmd(0, 1, 0, 1'b0);
    issue(2'd0);
    check("t3_pronto_c1", {31'd0, pronto}, 32'd1);
    wait_idle();

    // 4: abort during the second quarter turn
    expect_cmd(13, 13 + CA + 1, 1, 1'b1);
    issue(2'd2);
    repeat (12) @(negedge clock);
    check("t4_rest_pre", {30'd0, db_rest}, 32'd1);
    abortar = 1'b1;
    @(negedge clock);
    abortar = 1'b0;
    check("t4_posicao_fall", {31'd0, posicao}, 32'd0);
    check("t4_rest_cleared", {30'd0, db_rest}, 32'd0);
    check("t4_estado", {29'd0, db_estado}, 32'd2);
    wait_idle();
    repeat (3) @(negedge clock);
    check("t4_abortado_sticky", {31'd0, abortado}, 32'd1);
    // abort while settling is ignored; abortado clears on acceptance
    expect_cmd(CQ, CQ + CA + 1, 1, 1'b0);
    issue(2'd1);
    check("t4_abortado_clear", {31'd0, abortado}, 32'd0);
    repeat (11) @(negedge clock);
    abortar = 1'b1;
    @(negedge clock);
    abortar = 1'b0;
    wait_idle();

    // 5a: start request while busy is ignored
    expect_cmd(CQ, CQ + CA + 1, 1, 1'b0);
    issue(2'd1);
    repeat (4) @(negedge clock);
    iniciar = 1'b1;
    quartos = 2'd3;
    @(negedge clock);
    iniciar = 1'b0;
    check("t5_ignored_rest", {30'd0, db_rest}, 32'd1);
    wait_idle();

    // 5b: held start gives back-to-back commands with one idle cycle between
    expect_cmd(CQ, CQ + CA + 1, 1, 1'b0);
    iniciar = 1'b1;
    quartos = 2'd1;
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!pronto && n < 100);
    check("t5_held_first_pronto", {31'd0, pronto}, 32'd1);
    expect_cmd(CQ, CQ + CA + 1, 1, 1'b0);
    @(negedge clock);
    check("t5_held_gap_idle", {31'd0, ocupado}, 32'd0);
    @(negedge clock);
    check("t5_held_second_rise", {31'd0, posicao}, 32'd1);
    iniciar = 1'b0;
    wait_idle();

    // 6: asynchronous reset mid-rotation
    issue(2'd2);
    repeat (3) @(negedge clock);
    #2 reset_n = 1'b0;
    #1;
    check("t6_posicao", {31'd0, posicao}, 32'd0);
    check("t6_ocupado", {31'd0, ocupado}, 32'd0);
    check("t6_pronto", {31'd0, pronto}, 32'd0);
    check("t6_estado", {29'd0, db_estado}, 32'd0);
    @(negedge clock);
    #3 reset_n = 1'b1;
    @(negedge clock);
    check("t6_idle_after", {31'd0, ocupado}, 32'd0);
    expect_cmd(CQ, CQ + CA + 1, 1, 1'b0);
    issue(2'd1);
    check("t6_restart_rise", {31'd0, posicao}, 32'd1);
    wait_idle();

    repeat (5) @(negedge clock);
    check("pending_expectations", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
